// File: rtl/hazard_unit_p.sv
// Hazard unit for the 5-stage MIPS pipeline: stall/flush/forward controls,
// MDU busy interlock and a saturating stall-cycle counter.
module hazard_unit_p #(
    parameter int REG_W   = 5,
    parameter int FWD_EN  = 1,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BranchD,
    input  logic             BranchTakenD,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic             MemToRegE,
    input  logic             RegWriteE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic             MemToRegM,
    input  logic             RegWriteM,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic             RegWriteW,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             MduStartE,
    input  logic             MduUseD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MduBusy,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [3:0] MDU_LAT_C = 4'(MDU_LAT);

    logic [3:0]       mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             lw_stall, branch_stall, raw_stall, mdu_stall, stall, mdu_busy;
    logic [1:0]       fwd_ae, fwd_be;
    logic             fwd_ad, fwd_bd;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (RegWriteM && hit(src, WriteRegM)) begin
            sel = 2'b10;
        end else if (RegWriteW && hit(src, WriteRegW)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_ae    = 2'b00;
        fwd_be    = 2'b00;
        fwd_ad    = 1'b0;
        fwd_bd    = 1'b0;
        raw_stall = 1'b0;
        if (FWD_EN != 0) begin
            fwd_ae = fwd_sel(RsE);
            fwd_be = fwd_sel(RtE);
            fwd_ad = RegWriteM && hit(RsD, WriteRegM);
            fwd_bd = RegWriteM && hit(RtD, WriteRegM);
        end else begin
            // Without bypass paths any in-flight E/M writer of a D source must drain.
            raw_stall = (RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
                        (RegWriteM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM)));
        end

        lw_stall     = MemToRegE && (hit(RsD, RtE) || hit(RtD, RtE));
        branch_stall = BranchD &&
                       ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
                        (MemToRegM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
        mdu_busy     = MduStartE || (mdu_cnt_q != 4'd0);
        mdu_stall    = MduUseD && mdu_busy;
        stall        = lw_stall || branch_stall || raw_stall || mdu_stall;

        if (MduStartE) begin
            mdu_cnt_d = MDU_LAT_C;
        end else if (mdu_cnt_q != 4'd0) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end else begin
            mdu_cnt_d = mdu_cnt_q;
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        // Reset masks every control output regardless of the stage inputs.
        StallF    = !rst && stall;
        StallD    = !rst && stall;
        FlushE    = !rst && stall;
        FlushD    = !rst && BranchTakenD && !stall;
        ForwardAD = !rst && fwd_ad;
        ForwardBD = !rst && fwd_bd;
        ForwardAE = rst ? 2'b00 : fwd_ae;
        ForwardBE = rst ? 2'b00 : fwd_be;
        MduBusy   = !rst && mdu_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_cnt_q   <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_p.sv
// Bench for hazard_unit_p: directed and random stage patterns, scoreboarded
// against a cycle-level reference model across three parameter builds.
module tb_hazard_unit_p;

    localparam int LAT = 4;

    typedef struct packed {
        logic       rst;
        logic       BranchD;
        logic       BranchTakenD;
        logic [4:0] RsD;
        logic [4:0] RtD;
        logic [4:0] RsE;
        logic [4:0] RtE;
        logic       MemToRegE;
        logic       RegWriteE;
        logic [4:0] WriteRegE;
        logic       MemToRegM;
        logic       RegWriteM;
        logic [4:0] WriteRegM;
        logic       RegWriteW;
        logic [4:0] WriteRegW;
        logic       MduStartE;
        logic       MduUseD;
    } stim_t;

    typedef struct packed {
        logic [10:0] p_main;
        logic [10:0] p_fwd0;
        logic [31:0] c_main;
        logic [31:0] c_fwd0;
        logic [3:0]  c_4;
    } expect_t;

    logic  clk = 1'b0;
    stim_t cur = '0;
    expect_t sb_q[$];
    bit    drv_done = 1'b0;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    logic        m_sf, m_sd, m_fd, m_fe, m_ad, m_bd, m_busy;
    logic [1:0]  m_ae, m_be;
    logic [31:0] m_cnt;
    logic        f_sf, f_sd, f_fd, f_fe, f_ad, f_bd, f_busy;
    logic [1:0]  f_ae, f_be;
    logic [31:0] f_cnt;
    logic        s_sf, s_sd, s_fd, s_fe, s_ad, s_bd, s_busy;
    logic [1:0]  s_ae, s_be;
    logic [3:0]  s_cnt;

    hazard_unit_p #(.REG_W(5), .FWD_EN(1), .MDU_LAT(LAT), .CNT_W(32)) u_main (
        .clk(clk), .rst(cur.rst), .BranchD(cur.BranchD), .BranchTakenD(cur.BranchTakenD),
        .RsD(cur.RsD), .RtD(cur.RtD), .RsE(cur.RsE), .RtE(cur.RtE),
        .MemToRegE(cur.MemToRegE), .RegWriteE(cur.RegWriteE), .WriteRegE(cur.WriteRegE),
        .MemToRegM(cur.MemToRegM), .RegWriteM(cur.RegWriteM), .WriteRegM(cur.WriteRegM),
        .RegWriteW(cur.RegWriteW), .WriteRegW(cur.WriteRegW),
        .MduStartE(cur.MduStartE), .MduUseD(cur.MduUseD),
        .StallF(m_sf), .StallD(m_sd), .FlushD(m_fd), .FlushE(m_fe),
        .ForwardAD(m_ad), .ForwardBD(m_bd), .ForwardAE(m_ae), .ForwardBE(m_be),
        .MduBusy(m_busy), .StallCount(m_cnt));

    hazard_unit_p #(.REG_W(5), .FWD_EN(0), .MDU_LAT(LAT), .CNT_W(32)) u_fwd0 (
        .clk(clk), .rst(cur.rst), .BranchD(cur.BranchD), .BranchTakenD(cur.BranchTakenD),
        .RsD(cur.RsD), .RtD(cur.RtD), .RsE(cur.RsE), .RtE(cur.RtE),
        .MemToRegE(cur.MemToRegE), .RegWriteE(cur.RegWriteE), .WriteRegE(cur.WriteRegE),
        .MemToRegM(cur.MemToRegM), .RegWriteM(cur.RegWriteM), .WriteRegM(cur.WriteRegM),
        .RegWriteW(cur.RegWriteW), .WriteRegW(cur.WriteRegW),
        .MduStartE(cur.MduStartE), .MduUseD(cur.MduUseD),
        .StallF(f_sf), .StallD(f_sd), .FlushD(f_fd), .FlushE(f_fe),
        .ForwardAD(f_ad), .ForwardBD(f_bd), .ForwardAE(f_ae), .ForwardBE(f_be),
        .MduBusy(f_busy), .StallCount(f_cnt));

    hazard_unit_p #(.REG_W(5), .FWD_EN(1), .MDU_LAT(LAT), .CNT_W(4)) u_cnt4 (
        .clk(clk), .rst(cur.rst), .BranchD(cur.BranchD), .BranchTakenD(cur.BranchTakenD),
        .RsD(cur.RsD), .RtD(cur.RtD), .RsE(cur.RsE), .RtE(cur.RtE),
        .MemToRegE(cur.MemToRegE), .RegWriteE(cur.RegWriteE), .WriteRegE(cur.WriteRegE),
        .MemToRegM(cur.MemToRegM), .RegWriteM(cur.RegWriteM), .WriteRegM(cur.WriteRegM),
        .RegWriteW(cur.RegWriteW), .WriteRegW(cur.WriteRegW),
        .MduStartE(cur.MduStartE), .MduUseD(cur.MduUseD),
        .StallF(s_sf), .StallD(s_sd), .FlushD(s_fd), .FlushE(s_fe),
        .ForwardAD(s_ad), .ForwardBD(s_bd), .ForwardAE(s_ae), .ForwardBE(s_be),
        .MduBusy(s_busy), .StallCount(s_cnt));

    // Reference: hazard rules written directly from the pipeline description.
    function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [10:0] model(input stim_t s, input bit fe, input bit busy,
                                          output bit stall);
        logic [1:0] ae, be;
        bit ad, bd, lw, br, raw, mdu;
        ae = 2'b00; be = 2'b00; ad = 0; bd = 0; raw = 0;
        if (fe) begin
            if (s.RegWriteM && dep(s.RsE, s.WriteRegM)) ae = 2'b10;
            else if (s.RegWriteW && dep(s.RsE, s.WriteRegW)) ae = 2'b01;
            if (s.RegWriteM && dep(s.RtE, s.WriteRegM)) be = 2'b10;
            else if (s.RegWriteW && dep(s.RtE, s.WriteRegW)) be = 2'b01;
            ad = s.RegWriteM && dep(s.RsD, s.WriteRegM);
            bd = s.RegWriteM && dep(s.RtD, s.WriteRegM);
        end else begin
            raw = (s.RegWriteE && (dep(s.RsD, s.WriteRegE) || dep(s.RtD, s.WriteRegE))) ||
                  (s.RegWriteM && (dep(s.RsD, s.WriteRegM) || dep(s.RtD, s.WriteRegM)));
        end
        lw  = s.MemToRegE && (dep(s.RsD, s.RtE) || dep(s.RtD, s.RtE));
        br  = s.BranchD && ((s.RegWriteE && (dep(s.RsD, s.WriteRegE) || dep(s.RtD, s.WriteRegE))) ||
                            (s.MemToRegM && (dep(s.RsD, s.WriteRegM) || dep(s.RtD, s.WriteRegM))));
        mdu = s.MduUseD && busy;
        stall = lw || br || raw || mdu;
        if (s.rst) return 11'd0;
        return {stall, stall, (s.BranchTakenD && !stall), stall, ad, bd, ae, be, busy};
    endfunction

    // Model state: cycle index, last busy cycle, and stall tallies per build.
    stim_t  prev = '0;
    bit     prev_st_m = 0, prev_st_f = 0;
    int     cyc = 0;
    int     busy_until = -1;
    longint cnt_m = 0, cnt_f = 0, cnt_4 = 0;

    task automatic step(input stim_t s);
        expect_t e;
        bit busy, st_m, st_f;
        @(posedge clk);
        #1;
        if (prev.rst) begin
            cnt_m = 0; cnt_f = 0; cnt_4 = 0; busy_until = -1;
        end else begin
            if (prev_st_m && cnt_m < 64'hFFFF_FFFF) cnt_m++;
            if (prev_st_f && cnt_f < 64'hFFFF_FFFF) cnt_f++;
            if (prev_st_m && cnt_4 < 15) cnt_4++;
            if (prev.MduStartE) busy_until = cyc - 1 + LAT;
        end
        busy = !s.rst && (s.MduStartE || cyc <= busy_until);
        cur = s;
        e.p_main = model(s, 1'b1, busy, st_m);
        e.p_fwd0 = model(s, 1'b0, busy, st_f);
        e.c_main = 32'(cnt_m);
        e.c_fwd0 = 32'(cnt_f);
        e.c_4    = 4'(cnt_4);
        sb_q.push_back(e);
        prev = s; prev_st_m = st_m; prev_st_f = st_f;
        cyc++;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst          = ($urandom_range(0, 49) == 0);
        s.BranchD      = $urandom_range(0, 3) == 0;
        s.BranchTakenD = $urandom_range(0, 2) == 0;
        s.RsD          = 5'($urandom_range(0, 4));
        s.RtD          = 5'($urandom_range(0, 4));
        s.RsE          = 5'($urandom_range(0, 4));
        s.RtE          = 5'($urandom_range(0, 4));
        s.MemToRegE    = $urandom_range(0, 3) == 0;
        s.RegWriteE    = 1'($urandom);
        s.WriteRegE    = 5'($urandom_range(0, 4));
        s.MemToRegM    = $urandom_range(0, 3) == 0;
        s.RegWriteM    = 1'($urandom);
        s.WriteRegM    = 5'($urandom_range(0, 4));
        s.RegWriteW    = 1'($urandom);
        s.WriteRegW    = 5'($urandom_range(0, 4));
        s.MduStartE    = $urandom_range(0, 9) == 0;
        s.MduUseD      = $urandom_range(0, 2) == 0;
        return s;
    endfunction

    initial begin : driver
        stim_t s;
        cur = '0;
        cur.rst = 1'b1;
        prev = cur;
        repeat (2) @(posedge clk);
        s = '0; s.RsE = 5'd8; s.WriteRegM = 5'd8; s.RegWriteM = 1; s.WriteRegW = 5'd8; s.RegWriteW = 1;
        step(s);
        s.RegWriteM = 0; step(s);
        s.RsE = 5'd0; step(s);
        s = '0; s.MemToRegE = 1; s.RtE = 5'd9; s.RsD = 5'd9; step(s);
        s = '0; step(s); step(s);
        s = '0; s.BranchD = 1; s.BranchTakenD = 1; s.RsD = 5'd4; s.RegWriteE = 1; s.WriteRegE = 5'd4;
        step(s);
        s.RegWriteE = 0; step(s);
        s = '0; s.MduStartE = 1; step(s);
        s = '0; s.MduUseD = 1; repeat (6) step(s);
        s = '0; s.RegWriteM = 1; s.WriteRegM = 5'd3; s.RtD = 5'd3; step(s);
        s = '0; s.MemToRegE = 1; s.RtE = 5'd9; s.RsD = 5'd9; repeat (20) step(s);
        s = '0; s.MduStartE = 1; s.MduUseD = 1; step(s);
        s = '0; s.rst = 1; s.MduUseD = 1; s.MemToRegE = 1; s.RtE = 5'd2; s.RsD = 5'd2; step(s);
        s = '0; s.MduUseD = 1; repeat (2) step(s);
        for (int i = 0; i < 1500; i++) step(rand_stim());
        @(posedge clk);
        drv_done = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    initial begin : monitor
        expect_t e;
        bit finished = 0;
        for (int n = 0; n < 20000 && !finished; n++) begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("main_ctrl", 32'({m_sf, m_sd, m_fd, m_fe, m_ad, m_bd, m_ae, m_be, m_busy}), 32'(e.p_main));
                chk("fwd0_ctrl", 32'({f_sf, f_sd, f_fd, f_fe, f_ad, f_bd, f_ae, f_be, f_busy}), 32'(e.p_fwd0));
                chk("cnt4_ctrl", 32'({s_sf, s_sd, s_fd, s_fe, s_ad, s_bd, s_ae, s_be, s_busy}), 32'(e.p_main));
                chk("main_count", m_cnt, e.c_main);
                chk("fwd0_count", f_cnt, e.c_fwd0);
                chk("cnt4_count", 32'(s_cnt), 32'(e.c_4));
            end else if (drv_done) begin
                finished = 1;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout got=pending exp=done");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
